// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-feedback signal bundle for branch_predictor.
// master = pipeline side (fetch/execute), slave = predictor.
interface branch_predictor_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            pred_hit;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic            upd_is_branch;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output pred_pc, upd_valid, upd_is_branch, upd_pc, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_hit, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  pred_pc, upd_valid, upd_is_branch, upd_pc, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_hit, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter + tagged BTB direction/target predictor with a clear sweep.
// Optional BP_PERF_EN adds resolved-branch and mispredict counters.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_predictor_if.slave   bus,
  input  logic                clr,
  output logic                busy,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispredicts
);
  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [IDX_BITS-1:0] clr_idx;

  logic                vld_tab [ENTRIES];
  logic [1:0]          ctr_tab [ENTRIES];
  logic [TAG_BITS-1:0] tag_tab [ENTRIES];
  logic [XLEN-1:0]     tgt_tab [ENTRIES];

  logic [IDX_BITS-1:0] p_idx, u_idx;
  logic [TAG_BITS-1:0] p_tag, u_tag;
  logic                p_hit, u_hit, upd_q, is_br;
  logic                pc_unused;

  assign p_idx = bus.pred_pc[IDX_BITS+1:2];
  assign p_tag = bus.pred_pc[IDX_BITS+2 +: TAG_BITS];
  assign u_idx = bus.upd_pc[IDX_BITS+1:2];
  assign u_tag = bus.upd_pc[IDX_BITS+2 +: TAG_BITS];
  assign pc_unused = ^{bus.pred_pc[1:0], bus.pred_pc[XLEN-1:IDX_BITS+2+TAG_BITS]};

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign p_hit           = !busy && vld_tab[p_idx] && (tag_tab[p_idx] == p_tag);
  assign bus.pred_hit    = p_hit;
  assign bus.pred_taken  = p_hit && ctr_tab[p_idx][1];
  assign bus.pred_target = p_hit ? tgt_tab[p_idx] : '0;

  assign is_br = bus.upd_valid && bus.upd_is_branch;
  assign upd_q = is_br && !busy;
  assign u_hit = vld_tab[u_idx] && (tag_tab[u_idx] == u_tag);

  assign bus.mispredict  = is_br &&
                           ((bus.upd_taken != bus.upd_pred_taken) ||
                            (bus.upd_taken && bus.upd_pred_taken &&
                             (bus.upd_target != bus.upd_pred_target)));
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      clr_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + IDX_BITS'(1);
          if (&clr_idx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        vld_tab[i] <= 1'b0;
        ctr_tab[i] <= 2'b01;
        tag_tab[i] <= '0;
        tgt_tab[i] <= '0;
      end
    end else if (state == CLEAR) begin
      vld_tab[clr_idx] <= 1'b0;
      ctr_tab[clr_idx] <= 2'b01;
    end else if (upd_q) begin
      if (u_hit) begin
        if (bus.upd_taken) begin
          if (ctr_tab[u_idx] != 2'b11) ctr_tab[u_idx] <= ctr_tab[u_idx] + 2'b01;
          tgt_tab[u_idx] <= bus.upd_target;
        end else if (ctr_tab[u_idx] != 2'b00) begin
          ctr_tab[u_idx] <= ctr_tab[u_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        vld_tab[u_idx] <= 1'b1;
        tag_tab[u_idx] <= u_tag;
        tgt_tab[u_idx] <= bus.upd_target;
        ctr_tab[u_idx] <= 2'b10;
      end
    end
  end

`ifdef BP_PERF_EN
  // Counters survive clr; only rst_n zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      perf_branches    <= perf_branches + 32'(upd_q);
      perf_mispredicts <= perf_mispredicts + 32'(bus.mispredict);
    end
  end
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif
endmodule
